float_unit_arbiter: RTL

// - Shares one float_multiplier or float_adder instance between N_REQ requesters (e.g. multiple
//   iir_lpf channels or filter stages) so an ECG pipeline does not instantiate one FP unit per user.
// - Uses the same STB/ACK operand/result handshake as the FP units on both sides.
// - Round-robin grant with one operation in flight.
// - Result is routed back only to the requester that issued it.
//

---
 rtl/float_unit_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/float_unit_arbiter.sv
`default_nettype none
// ============================================================================
// float_unit_arbiter: shares one STB/ACK floating-point unit among N_REQ users.
// Optional macro FPU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index).
// Revision: 1.0
// ============================================================================
module float_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int IDX_W = 2
) (
    input  logic                i_CLK,
    input  logic                i_RSTN,
    input  logic [N_REQ*DW-1:0] i_REQ_A,
    input  logic [N_REQ*DW-1:0] i_REQ_B,
    input  logic [N_REQ-1:0]    i_REQ_STB,
    output logic [N_REQ-1:0]    o_REQ_ACK,
    output logic [DW-1:0]       o_RSP_Z,
    output logic [N_REQ-1:0]    o_RSP_STB,
    input  logic [N_REQ-1:0]    i_RSP_ACK,
    output logic [DW-1:0]       o_FU_A,
    output logic [DW-1:0]       o_FU_B,
    output logic                o_FU_AB_STB,
    input  logic                i_FU_AB_ACK,
    input  logic [DW-1:0]       i_FU_Z,
    input  logic                i_FU_Z_STB,
    output logic                o_FU_Z_ACK,
    output logic                o_BUSY,
    output logic [IDX_W-1:0]    o_GRANT_IDX
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_Z = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   gnt_d;
    logic               found_d;
    logic [IDX_W-1:0]   rr_ptr_d;

    // Search starts at the pointer and wraps, so the first hit is the RR winner.
    always_comb begin
        int k;
        found_d = 1'b0;
        gnt_d   = '0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!found_d && i_REQ_STB[k]) begin
                found_d = 1'b1;
                gnt_d   = IDX_W'(k);
            end
        end
    end

    always_comb begin
`ifdef FPU_ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        rr_ptr_d = (o_GRANT_IDX == IDX_W'(N_REQ - 1)) ? '0 : o_GRANT_IDX + 1'b1;
`endif
    end

    assign o_BUSY = (state_q != ST_IDLE);

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            o_REQ_ACK   <= '0;
            o_RSP_Z     <= '0;
            o_RSP_STB   <= '0;
            o_FU_A      <= '0;
            o_FU_B      <= '0;
            o_FU_AB_STB <= 1'b0;
            o_FU_Z_ACK  <= 1'b0;
            o_GRANT_IDX <= '0;
        end else begin
            o_REQ_ACK  <= '0;
            o_FU_Z_ACK <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        o_FU_A      <= i_REQ_A[int'(gnt_d)*DW +: DW];
                        o_FU_B      <= i_REQ_B[int'(gnt_d)*DW +: DW];
                        o_GRANT_IDX <= gnt_d;
                        o_REQ_ACK   <= N_REQ'(1) << gnt_d;
                        o_FU_AB_STB <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_FU_AB_ACK) begin
                        o_FU_AB_STB <= 1'b0;
                        state_q     <= ST_WAIT_Z;
                    end
                end
                ST_WAIT_Z: begin
                    if (i_FU_Z_STB) begin
                        o_RSP_Z    <= i_FU_Z;
                        o_FU_Z_ACK <= 1'b1;
                        o_RSP_STB  <= N_REQ'(1) << o_GRANT_IDX;
                        state_q    <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    // Only the granted requester's ack releases the result.
                    if (i_RSP_ACK[o_GRANT_IDX]) begin
                        o_RSP_STB <= '0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    o_FU_AB_STB <= 1'b0;
                    o_RSP_STB   <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
